// File: rtl/tcam_pkg.sv
// Shared types and constants for the TCAM lookup controller.
package tcam_pkg;

    // Controller state: normal operation or table-clear sweep.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Cycles from lookup acceptance to res_vld.
    localparam int unsigned RES_LATENCY = 3;

    // entry_count must represent 0..DEPTH inclusive.
    function automatic int unsigned count_width(input int unsigned depth_bits);
        return depth_bits + 1;
    endfunction

endpackage

// File: rtl/tcam_lookup_ctrl_if.sv
// Lookup, result and table-write channels of the TCAM lookup controller.
interface tcam_lookup_ctrl_if #(
    parameter int unsigned CMP_WIDTH  = 32,
    parameter int unsigned DEPTH_BITS = 5,
    parameter int unsigned TAG_WIDTH  = 8
);
    logic                  lkup_req;
    logic                  lkup_rdy;
    logic [CMP_WIDTH-1:0]  lkup_key;
    logic [TAG_WIDTH-1:0]  lkup_tag;

    logic                  res_vld;
    logic                  res_hit;
    logic [DEPTH_BITS-1:0] res_addr;
    logic [TAG_WIDTH-1:0]  res_tag;

    logic                  wr_req;
    logic                  wr_rdy;
    logic [DEPTH_BITS-1:0] wr_addr;
    logic [CMP_WIDTH-1:0]  wr_data;
    logic [CMP_WIDTH-1:0]  wr_mask;
    logic                  wr_entry_vld;

    modport master (
        output lkup_req, lkup_key, lkup_tag,
        output wr_req, wr_addr, wr_data, wr_mask, wr_entry_vld,
        input  lkup_rdy, wr_rdy,
        input  res_vld, res_hit, res_addr, res_tag
    );

    modport slave (
        input  lkup_req, lkup_key, lkup_tag,
        input  wr_req, wr_addr, wr_data, wr_mask, wr_entry_vld,
        output lkup_rdy, wr_rdy,
        output res_vld, res_hit, res_addr, res_tag
    );
endinterface

// File: rtl/tcam_prio_encoder.sv
// Lowest-index-wins priority encoder: match vector -> {hit, index}.
module tcam_prio_encoder #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DEPTH_BITS = 5
) (
    input  logic [DEPTH-1:0]      vec,
    output logic                  hit,
    output logic [DEPTH_BITS-1:0] idx
);

    // Scan from the top down so the smallest set index is the last one assigned.
    always_comb begin
        hit = |vec;
        idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = DEPTH_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_lookup_ctrl.sv
// TCAM lookup controller: owns the ternary table, serialises writes, lookups and
// clear sweeps, and returns one tagged result per lookup at fixed latency.
module tcam_lookup_ctrl
    import tcam_pkg::*;
#(
    parameter int unsigned CMP_WIDTH  = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DEPTH_BITS = 5,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    tcam_lookup_ctrl_if.slave                    bus,
    input  logic                                 clr_req,
    output logic                                 busy,
    output logic                                 clr_done,
    output logic [count_width(DEPTH_BITS)-1:0]   entry_count
);

    localparam int unsigned CNT_W = count_width(DEPTH_BITS);
    localparam logic [DEPTH_BITS-1:0] LAST_IDX = DEPTH_BITS'(DEPTH - 1);

    state_e                state_q;
    logic [DEPTH_BITS-1:0] sweep_idx_q;
    logic                  clr_done_q;

    logic [CMP_WIDTH-1:0]  data_q [DEPTH];
    logic [CMP_WIDTH-1:0]  mask_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [CNT_W-1:0]      count_q;

    logic [RES_LATENCY-1:0] vld_pipe_q;
    logic [CMP_WIDTH-1:0]   key_q;
    logic [TAG_WIDTH-1:0]   tag0_q;
    logic [TAG_WIDTH-1:0]   tag1_q;
    logic [DEPTH-1:0]       match_q;
    logic                   res_hit_q;
    logic [DEPTH_BITS-1:0]  res_addr_q;
    logic [TAG_WIDTH-1:0]   res_tag_q;

    logic                  wr_rdy;
    logic                  lkup_rdy;
    logic                  wr_fire;
    logic                  lkup_fire;
    logic                  wr_addr_ok;
    logic                  last_sweep;
    logic [DEPTH-1:0]      match_vec;
    logic                  enc_hit;
    logic [DEPTH_BITS-1:0] enc_addr;

    // Clear wins over write, write wins over lookup.
    assign wr_rdy     = (state_q == ST_IDLE) & ~clr_req;
    assign lkup_rdy   = (state_q == ST_IDLE) & ~bus.wr_req & ~clr_req;
    assign wr_fire    = bus.wr_req & wr_rdy;
    assign lkup_fire  = bus.lkup_req & lkup_rdy;
    // Out-of-range addresses only exist for non-power-of-2 DEPTH; they are accepted and dropped.
    assign wr_addr_ok = 32'(bus.wr_addr) < DEPTH;
    assign last_sweep = (state_q == ST_CLEAR) && (sweep_idx_q == LAST_IDX);

    // FSM: idle or sweeping; clr_done is registered so it lines up with the last sweep index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sweep_idx_q <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q     <= ST_CLEAR;
                        sweep_idx_q <= '0;
                        clr_done_q  <= (DEPTH == 1);
                    end
                end
                ST_CLEAR: begin
                    if (sweep_idx_q == LAST_IDX) begin
                        state_q    <= ST_IDLE;
                        clr_done_q <= 1'b0;
                    end else begin
                        sweep_idx_q <= sweep_idx_q + 1'b1;
                        clr_done_q  <= ((sweep_idx_q + 1'b1) == LAST_IDX);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Table storage: sweep clears one entry per cycle, otherwise accepted writes land here.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            data_q[sweep_idx_q]  <= '0;
            mask_q[sweep_idx_q]  <= '0;
            valid_q[sweep_idx_q] <= 1'b0;
        end else if (wr_fire && wr_addr_ok) begin
            data_q[bus.wr_addr]  <= bus.wr_data;
            mask_q[bus.wr_addr]  <= bus.wr_mask;
            valid_q[bus.wr_addr] <= bus.wr_entry_vld;
        end
    end

    // Valid-entry counter tracks only valid-bit transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (last_sweep) begin
            count_q <= '0;
        end else if (wr_fire && wr_addr_ok) begin
            if (bus.wr_entry_vld && !valid_q[bus.wr_addr]) begin
                count_q <= count_q + 1'b1;
            end else if (!bus.wr_entry_vld && valid_q[bus.wr_addr]) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Ternary compare of the registered key against every entry; mask bit 1 is don't-care.
    always_comb begin
        match_vec = '0;
        for (int n = 0; n < int'(DEPTH); n++) begin
            match_vec[n] = (&((key_q ~^ data_q[n]) | mask_q[n])) & valid_q[n];
        end
    end

    tcam_prio_encoder #(
        .DEPTH      (DEPTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_prio_encoder (
        .vec (match_q),
        .hit (enc_hit),
        .idx (enc_addr)
    );

    // Lookup pipeline: key/tag capture, match-vector register, encoded result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            key_q      <= '0;
            tag0_q     <= '0;
            tag1_q     <= '0;
            match_q    <= '0;
            res_hit_q  <= 1'b0;
            res_addr_q <= '0;
            res_tag_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[RES_LATENCY-2:0], lkup_fire};
            if (lkup_fire) begin
                key_q  <= bus.lkup_key;
                tag0_q <= bus.lkup_tag;
            end
            if (vld_pipe_q[0]) begin
                match_q <= match_vec;
                tag1_q  <= tag0_q;
            end
            if (vld_pipe_q[1]) begin
                res_hit_q  <= enc_hit;
                res_addr_q <= enc_addr;
                res_tag_q  <= tag1_q;
            end
        end
    end

    assign bus.wr_rdy   = wr_rdy;
    assign bus.lkup_rdy = lkup_rdy;
    assign bus.res_vld  = vld_pipe_q[RES_LATENCY-1];
    assign bus.res_hit  = res_hit_q;
    assign bus.res_addr = res_addr_q;
    assign bus.res_tag  = res_tag_q;
    assign busy         = (state_q == ST_CLEAR);
    assign clr_done     = clr_done_q;
    assign entry_count  = count_q;

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Directed bench for tcam_lookup_ctrl with a result scoreboard.
module tb_tcam_lookup_ctrl;
    import tcam_pkg::*;

    localparam int unsigned CMP_WIDTH  = 32;
    localparam int unsigned DEPTH      = 32;
    localparam int unsigned DEPTH_BITS = 5;
    localparam int unsigned TAG_WIDTH  = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  clr_req = 1'b0;
    logic                  busy;
    logic                  clr_done;
    logic [DEPTH_BITS:0]   entry_count;

    tcam_lookup_ctrl_if #(
        .CMP_WIDTH  (CMP_WIDTH),
        .DEPTH_BITS (DEPTH_BITS),
        .TAG_WIDTH  (TAG_WIDTH)
    ) bus ();

    tcam_lookup_ctrl #(
        .CMP_WIDTH  (CMP_WIDTH),
        .DEPTH      (DEPTH),
        .DEPTH_BITS (DEPTH_BITS),
        .TAG_WIDTH  (TAG_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .clr_req     (clr_req),
        .busy        (busy),
        .clr_done    (clr_done),
        .entry_count (entry_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic                  hit;
        logic [DEPTH_BITS-1:0] addr;
        logic [TAG_WIDTH-1:0]  tag;
        int unsigned           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   res_cnt = 0;

    logic [31:0]           b2b_key  [8];
    logic                  b2b_hit  [8];
    logic [DEPTH_BITS-1:0] b2b_addr [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Result monitor: every res_vld must match the oldest pending expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.res_vld === 1'b1) begin
            res_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_res_vld", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("res_tag", 64'(bus.res_tag), 64'(e.tag));
                check("res_hit", 64'(bus.res_hit), 64'(e.hit));
                check("res_addr", 64'(bus.res_addr), 64'(e.addr));
                check("res_latency", 64'(cyc - e.acc_cyc), 64'(RES_LATENCY));
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        bus.lkup_req = 1'b0;
        bus.wr_req   = 1'b0;
        clr_req      = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] key, input logic [7:0] tag,
                          input logic exp_hit, input logic [DEPTH_BITS-1:0] exp_addr);
        exp_t e;
        @(negedge clk);
        bus.wr_req   = 1'b0;
        bus.lkup_req = 1'b1;
        bus.lkup_key = key;
        bus.lkup_tag = tag;
        #1;
        check("lkup_rdy", 64'(bus.lkup_rdy), 64'd1);
        if (bus.lkup_rdy === 1'b1) begin
            e.hit     = exp_hit;
            e.addr    = exp_addr;
            e.tag     = tag;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic write(input logic [DEPTH_BITS-1:0] addr, input logic [31:0] data,
                         input logic [31:0] mask, input logic vld);
        @(negedge clk);
        bus.lkup_req     = 1'b0;
        bus.wr_req       = 1'b1;
        bus.wr_addr      = addr;
        bus.wr_data      = data;
        bus.wr_mask      = mask;
        bus.wr_entry_vld = vld;
        #1;
        check("wr_rdy", 64'(bus.wr_rdy), 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_count(input int unsigned exp);
        #1;
        check("entry_count", 64'(entry_count), 64'(exp));
    endtask

    initial begin
        int base;
        int busy_n;
        int rdy_n;
        int done_n;
        int done_at;

        b2b_key  = '{32'h0A000001, 32'hC0A80000, 32'hDEADBEEF, 32'h0AFFFFFF,
                     32'hC0A8FFFF, 32'h0B000000, 32'hC0A90000, 32'h0A0000FF};
        b2b_hit  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        b2b_addr = '{5'd3, 5'd5, 5'd0, 5'd3, 5'd5, 5'd0, 5'd0, 5'd3};

        bus.lkup_req     = 1'b0;
        bus.lkup_key     = '0;
        bus.lkup_tag     = '0;
        bus.wr_req       = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.wr_mask      = '0;
        bus.wr_entry_vld = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_res_vld", 64'(bus.res_vld), 64'd0);
        check("rst_res_hit", 64'(bus.res_hit), 64'd0);
        check("rst_res_addr", 64'(bus.res_addr), 64'd0);
        check("rst_res_tag", 64'(bus.res_tag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_clr_done", 64'(clr_done), 64'd0);
        check("rst_lkup_rdy", 64'(bus.lkup_rdy), 64'd1);
        check("rst_wr_rdy", 64'(bus.wr_rdy), 64'd1);
        check_count(0);

        // Empty table misses.
        lookup(32'h0, 8'h11, 1'b0, 5'd0);
        idle();
        wait_drain();

        // Single masked entry.
        write(5'd3, 32'h0A000000, 32'h00FFFFFF, 1'b1);
        idle();
        check_count(1);
        lookup(32'h0A123456, 8'h5A, 1'b1, 5'd3);
        idle();
        wait_drain();

        // Priority: lower index wins; rewrite of a valid entry keeps the count.
        write(5'd1, 32'h0A120000, 32'h0000FFFF, 1'b1);
        write(5'd3, 32'h0A000000, 32'h00FFFFFF, 1'b1);
        idle();
        check_count(2);
        lookup(32'h0A12BEEF, 8'h31, 1'b1, 5'd1);
        idle();
        wait_drain();
        write(5'd1, 32'h0, 32'h0, 1'b0);
        idle();
        check_count(1);
        lookup(32'h0A12BEEF, 8'h32, 1'b1, 5'd3);
        idle();
        wait_drain();
        // Deleting an already invalid entry leaves the count alone.
        write(5'd9, 32'h0, 32'h0, 1'b0);
        idle();
        check_count(1);

        // Write beats a same-cycle lookup; next-cycle lookup sees the new entry.
        @(negedge clk);
        bus.wr_req       = 1'b1;
        bus.wr_addr      = 5'd5;
        bus.wr_data      = 32'hC0A80000;
        bus.wr_mask      = 32'h0000FFFF;
        bus.wr_entry_vld = 1'b1;
        bus.lkup_req     = 1'b1;
        bus.lkup_key     = 32'hC0A81234;
        bus.lkup_tag     = 8'h44;
        #1;
        check("collide_lkup_rdy", 64'(bus.lkup_rdy), 64'd0);
        check("collide_wr_rdy", 64'(bus.wr_rdy), 64'd1);
        lookup(32'hC0A81234, 8'h44, 1'b1, 5'd5);
        idle();
        wait_drain();
        check_count(2);

        // Back-to-back lookups, tags 0..7, results in order one per cycle.
        #1;
        base = res_cnt;
        for (int i = 0; i < 8; i++) begin
            lookup(b2b_key[i], 8'(i), b2b_hit[i], b2b_addr[i]);
        end
        idle();
        wait_drain();
        check("b2b_pulses", 64'(res_cnt - base), 64'd8);

        // Clear sweep with four valid entries; requests held high must be refused.
        write(5'd0, 32'hFFFFFFFF, 32'h0, 1'b1);
        write(5'd7, 32'h12345678, 32'h000000FF, 1'b1);
        idle();
        check_count(4);
        @(negedge clk);
        clr_req = 1'b1;
        bus.wr_req = 1'b1;
        bus.wr_addr = 5'd2;
        bus.wr_data = 32'h0;
        bus.wr_mask = 32'hFFFFFFFF;
        bus.wr_entry_vld = 1'b1;
        #1;
        check("clr_start_wr_rdy", 64'(bus.wr_rdy), 64'd0);
        check("clr_start_lkup_rdy", 64'(bus.lkup_rdy), 64'd0);
        busy_n = 0;
        rdy_n = 0;
        done_n = 0;
        done_at = -1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            clr_req = 1'b0;
            bus.lkup_req = 1'b1;
            bus.lkup_key = 32'hFFFFFFFF;
            #1;
            if (busy === 1'b1) busy_n++;
            if (bus.wr_rdy !== 1'b0 || bus.lkup_rdy !== 1'b0) rdy_n++;
            if (clr_done === 1'b1) begin
                done_n++;
                done_at = i;
            end
        end
        idle();
        #1;
        check("clr_busy_cycles", 64'(busy_n), 64'(DEPTH));
        check("clr_ready_leak", 64'(rdy_n), 64'd0);
        check("clr_done_pulses", 64'(done_n), 64'd1);
        check("clr_done_index", 64'(done_at), 64'(DEPTH - 1));
        check("clr_busy_after", 64'(busy), 64'd0);
        check("clr_done_after", 64'(clr_done), 64'd0);
        check_count(0);
        lookup(32'hFFFFFFFF, 8'h70, 1'b0, 5'd0);
        lookup(32'h0A123456, 8'h71, 1'b0, 5'd0);
        lookup(32'h00000000, 8'h72, 1'b0, 5'd0);
        idle();
        wait_drain();

        // Reset mid-pipeline discards the in-flight lookup.
        write(5'd4, 32'h0, 32'hFFFFFFFF, 1'b1);
        idle();
        check_count(1);
        lookup(32'h13572468, 8'h80, 1'b1, 5'd4);
        @(negedge clk);
        bus.lkup_req = 1'b0;
        reset = 1'b1;
        sb.delete();
        base = res_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("res_after_reset", 64'(res_cnt - base), 64'd0);
        check_count(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
